// File: rtl/fetch_pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_sequencer_pkg
//   Shared definitions for the fetch PC sequencer: resolved-instruction
//   opcodes, branch-control word bit positions and the sequencer FSM states.
// ---------------------------------------------------------------------------
package fetch_pc_sequencer_pkg;

   // Opcodes of the control-flow instructions seen at resolution time
   localparam logic [3:0] OP_B    = 4'b0110;
   localparam logic [3:0] OP_BR   = 4'b0111;
   localparam logic [3:0] OP_BLTZ = 4'b1000;
   localparam logic [3:0] OP_BZ   = 4'b1001;
   localparam logic [3:0] OP_BNZ  = 4'b1010;
   localparam logic [3:0] OP_BL   = 4'b1011;
   localparam logic [3:0] OP_BC   = 4'b1100;
   localparam logic [3:0] OP_BNC  = 4'b1101;

   // Bit positions inside the 3-bit branch-control word
   localparam int unsigned BC_TAKE   = 2;
   localparam int unsigned BC_REGSRC = 1;
   localparam int unsigned BC_SHORT  = 0;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_HALTED  = 2'd3
   } state_t;

   // Only bl writes the link register
   function automatic logic is_link_op(input logic [3:0] op);
      return (op == OP_BL);
   endfunction

endpackage

// File: rtl/fetch_pc_sequencer_next_pc_calc.sv
// ---------------------------------------------------------------------------
// fetch_pc_sequencer_next_pc_calc
//   Combinational next-PC selection from the branch-control word.
//   Ports:
//     i_pc          current PC
//     i_branch_ctl  [2] take, [1] register target, [0] short-offset form
//     i_reg_target  register-sourced target (low two bits ignored)
//     i_short_off   signed 22-bit word offset
//     i_long_off    signed 26-bit word offset
//     o_pc_plus4    sequential PC (also the link return address)
//     o_next_pc     selected next PC
//   All arithmetic wraps modulo 2^ADDR_W.
// ---------------------------------------------------------------------------
module fetch_pc_sequencer_next_pc_calc
   import fetch_pc_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [2:0]        i_branch_ctl,
   input  logic [ADDR_W-1:0] i_reg_target,
   input  logic [21:0]       i_short_off,
   input  logic [25:0]       i_long_off,
   output logic [ADDR_W-1:0] o_pc_plus4,
   output logic [ADDR_W-1:0] o_next_pc
);

   logic [ADDR_W-1:0] w_pc_plus4;
   logic [ADDR_W-1:0] w_short_disp;
   logic [ADDR_W-1:0] w_long_disp;
   logic [ADDR_W-1:0] w_reg_aligned;

   assign w_pc_plus4    = i_pc + ADDR_W'(4);
   // Word offsets: sign-extend to full width, then scale to bytes
   assign w_short_disp  = {{(ADDR_W-22){i_short_off[21]}}, i_short_off} << 2;
   assign w_long_disp   = {{(ADDR_W-26){i_long_off[25]}}, i_long_off} << 2;
   assign w_reg_aligned = i_reg_target & ~ADDR_W'(3);

   assign o_pc_plus4 = w_pc_plus4;

   // take=0 always falls through, which also covers the unused
   // register-source-without-take encodings
   always_comb begin
      o_next_pc = w_pc_plus4;
      if (i_branch_ctl[BC_TAKE]) begin
         if (i_branch_ctl[BC_REGSRC]) begin
            o_next_pc = w_reg_aligned;
         end else if (i_branch_ctl[BC_SHORT]) begin
            o_next_pc = w_pc_plus4 + w_short_disp;
         end else begin
            o_next_pc = w_pc_plus4 + w_long_disp;
         end
      end
   end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_pc_sequencer
//   Owns the program counter. Fetches one instruction over the imem req/ack
//   handshake, hands it to the core, waits for the core's resolution and
//   then applies the branch-control word to choose the next PC. Also emits
//   the link-register write for bl.
//   Ports:
//     clk, rst                   clock, async active-high reset
//     imem_req/addr/ack/rdata    instruction memory handshake (addr = pc)
//     instr, instr_valid/ready   instruction handoff to the core
//     res_valid, opcode          resolution of the issued instruction
//     branch_ctl, reg_target,
//     short_off, long_off        next-PC selection inputs
//     halt                       stop after the current resolution
//     link_we, link_data         one-cycle link register write (pc+4)
//     pc                         current PC
// ---------------------------------------------------------------------------
module fetch_pc_sequencer
   import fetch_pc_sequencer_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               res_valid,
   input  logic [3:0]         opcode,
   input  logic [2:0]         branch_ctl,
   input  logic [ADDR_W-1:0]  reg_target,
   input  logic [21:0]        short_off,
   input  logic [25:0]        long_off,
   input  logic               halt,
   output logic               link_we,
   output logic [ADDR_W-1:0]  link_data,
   output logic [ADDR_W-1:0]  pc
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDR_W-1:0]    r_pc;
   logic [INSTR_W-1:0]   r_instr;
   logic                 r_link_we;
   logic [ADDR_W-1:0]    r_link_data;

   logic                 w_in_fetch;
   logic                 w_in_issue;
   logic                 w_fetch_done;
   logic                 w_resolve;
   logic [ADDR_W-1:0]    w_pc_plus4;
   logic [ADDR_W-1:0]    w_next_pc;

   fetch_pc_sequencer_next_pc_calc #(
      .ADDR_W (ADDR_W)
   ) u_next_pc_calc (
      .i_pc         (r_pc),
      .i_branch_ctl (branch_ctl),
      .i_reg_target (reg_target),
      .i_short_off  (short_off),
      .i_long_off   (long_off),
      .o_pc_plus4   (w_pc_plus4),
      .o_next_pc    (w_next_pc)
   );

   // Next-state and per-state strobes. imem_ack and res_valid are only
   // looked at in their own states, so stray pulses elsewhere are dropped.
   always_comb begin
      w_state_nxt  = r_state;
      w_in_fetch   = 1'b0;
      w_in_issue   = 1'b0;
      w_fetch_done = 1'b0;
      w_resolve    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_in_fetch = 1'b1;
            if (imem_ack) begin
               w_fetch_done = 1'b1;
               w_state_nxt  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_in_issue = 1'b1;
            if (instr_ready) begin
               w_state_nxt = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            if (res_valid) begin
               w_resolve   = 1'b1;
               w_state_nxt = halt ? ST_HALTED : ST_FETCH;
            end
         end
         ST_HALTED: begin
            if (!halt) begin
               w_state_nxt = ST_FETCH;
            end
         end
         default: w_state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_FETCH;
         r_pc        <= RESET_PC;
         r_instr     <= '0;
         r_link_we   <= 1'b0;
         r_link_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_link_we <= 1'b0;
         if (w_fetch_done) begin
            r_instr <= imem_rdata;
         end
         if (w_resolve) begin
            r_pc <= w_next_pc;
            if (is_link_op(opcode)) begin
               r_link_we   <= 1'b1;
               r_link_data <= w_pc_plus4;
            end
         end
      end
   end

   // State resets to FETCH, so the request is masked while reset is held
   assign imem_req    = w_in_fetch & ~rst;
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign instr_valid = w_in_issue;
   assign link_we     = r_link_we;
   assign link_data   = r_link_data;
   assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
module tb_fetch_pc_sequencer;
   import fetch_pc_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        res_valid;
   logic [3:0]  opcode;
   logic [2:0]  branch_ctl;
   logic [31:0] reg_target;
   logic [21:0] short_off;
   logic [25:0] long_off;
   logic        halt;
   logic        link_we;
   logic [31:0] link_data;
   logic [31:0] pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_pc_sequencer #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .res_valid   (res_valid),
      .opcode      (opcode),
      .branch_ctl  (branch_ctl),
      .reg_target  (reg_target),
      .short_off   (short_off),
      .long_off    (long_off),
      .halt        (halt),
      .link_we     (link_we),
      .link_data   (link_data),
      .pc          (pc)
   );

   typedef struct {
      logic [31:0] rdata;
      int unsigned ack_dly;
      int unsigned rdy_dly;
      int unsigned res_dly;
      logic [3:0]  op;
      logic [2:0]  ctl;
      logic [31:0] rt;
      logic [21:0] so;
      logic [25:0] lo;
      logic        hbg;
      logic [31:0] exp_pc;
      logic        exp_lwe;
      logic [31:0] exp_ld;
   } vec_t;

   vec_t vecs [11];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b required=%0b", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT in FETCH at address cur_pc
   task automatic run_txn(input vec_t v, input logic [31:0] cur_pc, input logic res_halt);
      halt = v.hbg;
      chk1("fetch_req", imem_req, 1'b1);
      chk32("fetch_addr", imem_addr, cur_pc);
      for (int unsigned i = 0; i < v.ack_dly; i++) @(negedge clk);
      chk1("fetch_req_held", imem_req, 1'b1);
      imem_ack   = 1'b1;
      imem_rdata = v.rdata;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = '0;
      chk1("issue_valid", instr_valid, 1'b1);
      chk32("issue_instr", instr, v.rdata);
      chk1("issue_no_req", imem_req, 1'b0);
      // stray resolution and ack while waiting for the core
      for (int unsigned i = 0; i < v.rdy_dly; i++) begin
         res_valid  = 1'b1;
         opcode     = OP_BL;
         branch_ctl = 3'b111;
         reg_target = 32'hDEAD_0000;
         imem_ack   = 1'b1;
         imem_rdata = 32'hFFFF_FFFF;
         @(negedge clk);
         res_valid  = 1'b0;
         imem_ack   = 1'b0;
      end
      if (v.rdy_dly != 0) begin
         chk32("stray_instr", instr, v.rdata);
         chk32("stray_pc", pc, cur_pc);
         chk1("stray_link", link_we, 1'b0);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      chk1("resolve_valid_low", instr_valid, 1'b0);
      for (int unsigned i = 0; i < v.res_dly; i++) @(negedge clk);
      res_valid  = 1'b1;
      opcode     = v.op;
      branch_ctl = v.ctl;
      reg_target = v.rt;
      short_off  = v.so;
      long_off   = v.lo;
      halt       = res_halt;
      @(negedge clk);
      res_valid  = 1'b0;
      branch_ctl = 3'b000;
      chk32("next_pc", pc, v.exp_pc);
      chk1("link_we", link_we, v.exp_lwe);
      if (v.exp_lwe) chk32("link_data", link_data, v.exp_ld);
      if (res_halt) begin
         chk1("halt_no_req", imem_req, 1'b0);
      end else begin
         chk1("refetch_req", imem_req, 1'b1);
         chk32("refetch_addr", imem_addr, v.exp_pc);
      end
      @(negedge clk);
      chk1("link_pulse_end", link_we, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] cur;
      vec_t hv;

      //              rdata        ack rdy res op       ctl     rt            so            lo            hbg   exp_pc        lwe   ld
      vecs[0]  = '{32'h1234_5678, 1, 0, 0, OP_BZ,   3'b000, 32'h0,        22'h0,        26'h0,        1'b0, 32'h0000_0004, 1'b0, 32'h0};
      vecs[1]  = '{32'hA000_0001, 0, 1, 1, OP_BR,   3'b110, 32'h0000_0101, 22'h0,       26'h0,        1'b1, 32'h0000_0100, 1'b0, 32'h0};
      vecs[2]  = '{32'hA000_0002, 2, 0, 0, OP_BLTZ, 3'b101, 32'h0,        22'h3F_FFFE,  26'h0,        1'b0, 32'h0000_00FC, 1'b0, 32'h0};
      vecs[3]  = '{32'hA000_0003, 0, 0, 2, OP_BR,   3'b111, 32'h0000_0103, 22'h0,       26'h0,        1'b0, 32'h0000_0100, 1'b0, 32'h0};
      vecs[4]  = '{32'hA000_0004, 0, 2, 0, OP_BL,   3'b100, 32'h0,        22'h0,        26'h10,       1'b0, 32'h0000_0144, 1'b1, 32'h0000_0104};
      vecs[5]  = '{32'hA000_0005, 1, 0, 1, OP_BR,   3'b111, 32'h0000_0203, 22'h0,       26'h0,        1'b0, 32'h0000_0200, 1'b0, 32'h0};
      vecs[6]  = '{32'hA000_0006, 0, 0, 0, OP_BNZ,  3'b010, 32'h0000_0500, 22'h0,       26'h0,        1'b1, 32'h0000_0204, 1'b0, 32'h0};
      vecs[7]  = '{32'hA000_0007, 0, 1, 0, OP_BC,   3'b011, 32'h0000_0700, 22'h5,       26'h0,        1'b0, 32'h0000_0208, 1'b0, 32'h0};
      vecs[8]  = '{32'hA000_0008, 0, 0, 0, OP_BL,   3'b000, 32'h0,        22'h0,        26'h0,        1'b0, 32'h0000_020C, 1'b1, 32'h0000_020C};
      vecs[9]  = '{32'hA000_0009, 3, 0, 0, OP_B,    3'b100, 32'h0,        22'h0,        26'h3FF_FFFF, 1'b0, 32'h0000_020C, 1'b0, 32'h0};
      vecs[10] = '{32'hA000_000A, 0, 0, 0, OP_BR,   3'b111, 32'hFFFF_FFFF, 22'h0,       26'h0,        1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0};

      rst = 1'b1;
      imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0; res_valid = 1'b0;
      opcode = '0; branch_ctl = '0; reg_target = '0; short_off = '0; long_off = '0; halt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk32("rst_pc", pc, 32'h0);
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", instr_valid, 1'b0);
      chk1("rst_link_we", link_we, 1'b0);
      chk32("rst_link_data", link_data, 32'h0);
      chk32("rst_instr", instr, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      cur = 32'h0;
      for (int i = 0; i < 11; i++) begin
         run_txn(vecs[i], cur, 1'b0);
         cur = vecs[i].exp_pc;
      end

      // Wrap from 0xFFFFFFFC to 0 with halt on the resolution cycle
      hv = '{32'hB000_0001, 0, 0, 0, OP_BZ, 3'b000, 32'h0, 22'h0, 26'h0, 1'b0, 32'h0, 1'b0, 32'h0};
      run_txn(hv, cur, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk1("halted_no_req", imem_req, 1'b0);
         chk32("halted_pc", pc, 32'h0);
         @(negedge clk);
      end
      halt = 1'b0;
      @(negedge clk);
      chk1("resume_req", imem_req, 1'b1);
      chk32("resume_addr", imem_addr, 32'h0);

      // Most negative long offset
      hv = '{32'hB000_0002, 0, 0, 0, OP_BNC, 3'b100, 32'h0, 22'h0, 26'h200_0000, 1'b0, 32'hF800_0004, 1'b0, 32'h0};
      run_txn(hv, 32'h0, 1'b0);

      // Reset mid-fetch with an ack in the same cycle
      chk1("prerst_req", imem_req, 1'b1);
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      rst        = 1'b1;
      #1;
      chk32("midrst_pc", pc, 32'h0);
      chk1("midrst_req", imem_req, 1'b0);
      chk1("midrst_valid", instr_valid, 1'b0);
      @(negedge clk);
      rst      = 1'b0;
      imem_ack = 1'b0;
      chk32("midrst_instr", instr, 32'h0);
      chk1("midrst_valid2", instr_valid, 1'b0);
      @(negedge clk);
      hv = '{32'hC000_0001, 0, 0, 0, OP_B, 3'b000, 32'h0, 22'h0, 26'h0, 1'b0, 32'h0000_0004, 1'b0, 32'h0};
      run_txn(hv, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
